// File: rtl/tnn_column_if.sv
// Handshake and data bundle between a volley source and the tnn_column.
// The source drives start/training/spike_times; the column returns its status and result.
interface tnn_column_if #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int TBITS       = 3
) ();
  localparam int WIDX = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                             start;
  logic                             training;
  logic [NUM_INPUTS-1:0][TBITS:0]   spike_times;
  logic                             busy;
  logic                             done;
  logic [TBITS:0]                   out_spike_time;
  logic [WIDX-1:0]                  winner;
  logic                             winner_valid;

  modport master (
    output start, training, spike_times,
    input  busy, done, out_spike_time, winner, winner_valid
  );

  modport slave (
    input  start, training, spike_times,
    output busy, done, out_spike_time, winner, winner_valid
  );
endinterface

// File: rtl/tnn_column.sv
// Temporal neural network column: race-logic inference over a spike volley plus optional STDP learning.
// Define STDP_SEARCH_EN to let non-firing neurons grow weights toward active inputs.
module tnn_column #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int WBITS       = 3,
  parameter int TBITS       = 3,
  parameter int THRESH      = 6,
  parameter int WINIT       = 2,
  parameter int W_INC       = 1,
  parameter int W_DEC       = 1
) (
  input logic        clk,
  input logic        rst,
  tnn_column_if.slave bus
);
  localparam int WMAX    = (1 << WBITS) - 1;
  localparam int T_GAMMA = 1 << TBITS;
  localparam int IBITS   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int WIDX    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int PBITS   = WBITS + $clog2(NUM_INPUTS) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INFER = 2'd1;
  localparam logic [1:0] S_LEARN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TBITS:0] NO_SPIKE = '1;

  logic [1:0]                     state;
  logic [TBITS-1:0]               t;
  logic [IBITS-1:0]               col;
  logic [NUM_INPUTS-1:0][TBITS:0] lat_times;
  logic                           lat_training;
  logic [WBITS-1:0]               weights [NUM_NEURONS][NUM_INPUTS];
  logic [NUM_NEURONS-1:0]         fired;
  logic                           win_found;
  logic [WIDX-1:0]                win_idx;
  logic [TBITS-1:0]               win_time;

  logic [NUM_INPUTS-1:0]          active;
  logic [PBITS-1:0]               pot [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]         fire_now;
  logic                           first_found;
  logic [WIDX-1:0]                first_idx;
  logic                           eff_found;
  logic [WIDX-1:0]                eff_idx;
  logic [TBITS-1:0]               eff_time;
  logic [WBITS-1:0]               col_next [NUM_NEURONS];

  function automatic logic [WBITS-1:0] sat_inc(input logic [WBITS-1:0] w);
    int v;
    v = int'(w) + W_INC;
    if (v > WMAX) v = WMAX;
    return WBITS'(v);
  endfunction

  function automatic logic [WBITS-1:0] sat_dec(input logic [WBITS-1:0] w);
    int v;
    v = int'(w) - W_DEC;
    if (v < 0) v = 0;
    return WBITS'(v);
  endfunction

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);

  // t is frozen at T_GAMMA-1 after inference, so "active" during LEARN is the end-of-window view.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      active[i] = !lat_times[i][TBITS] && (lat_times[i][TBITS-1:0] <= t);
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      pot[n] = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (active[i]) pot[n] = pot[n] + PBITS'(weights[n][i]);
      end
      fire_now[n] = (state == S_INFER) && !fired[n] && (pot[n] >= PBITS'(THRESH));
    end
  end

  // Scanning downward leaves the lowest-index simultaneous firer as the candidate.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    for (int n = NUM_NEURONS - 1; n >= 0; n--) begin
      if (fire_now[n]) begin
        first_found = 1'b1;
        first_idx   = WIDX'(n);
      end
    end
  end

  assign eff_found = win_found | first_found;
  assign eff_idx   = win_found ? win_idx : first_idx;
  assign eff_time  = win_found ? win_time : t;

  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      col_next[n] = weights[n][col];
      if (win_found && (win_idx == WIDX'(n))) begin
        col_next[n] = active[col] ? sat_inc(weights[n][col]) : sat_dec(weights[n][col]);
      end else if (fired[n]) begin
        if (active[col]) col_next[n] = sat_dec(weights[n][col]);
      end else begin
`ifdef STDP_SEARCH_EN
        if (active[col]) col_next[n] = sat_inc(weights[n][col]);
`else
        col_next[n] = weights[n][col];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      t                  <= '0;
      col                <= '0;
      lat_times          <= '0;
      lat_training       <= 1'b0;
      fired              <= '0;
      win_found          <= 1'b0;
      win_idx            <= '0;
      win_time           <= '0;
      bus.out_spike_time <= NO_SPIKE;
      bus.winner         <= '0;
      bus.winner_valid   <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          weights[n][i] <= WBITS'(WINIT);
        end
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            lat_times    <= bus.spike_times;
            lat_training <= bus.training;
            t            <= '0;
            fired        <= '0;
            win_found    <= 1'b0;
            state        <= S_INFER;
          end
        end
        S_INFER: begin
          fired <= fired | fire_now;
          if (!win_found && first_found) begin
            win_found <= 1'b1;
            win_idx   <= first_idx;
            win_time  <= t;
          end
          if (t == TBITS'(T_GAMMA - 1)) begin
            col <= '0;
            if (lat_training) begin
              state <= S_LEARN;
            end else begin
              state              <= S_DONE;
              bus.out_spike_time <= eff_found ? {1'b0, eff_time} : NO_SPIKE;
              bus.winner         <= eff_found ? eff_idx : '0;
              bus.winner_valid   <= eff_found;
            end
          end else begin
            t <= t + 1'b1;
          end
        end
        S_LEARN: begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            weights[n][col] <= col_next[n];
          end
          if (col == IBITS'(NUM_INPUTS - 1)) begin
            state              <= S_DONE;
            bus.out_spike_time <= eff_found ? {1'b0, eff_time} : NO_SPIKE;
            bus.winner         <= eff_found ? eff_idx : '0;
            bus.winner_valid   <= eff_found;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tnn_column.sv
// Directed scoreboard bench for tnn_column: an independent volley model predicts results and weights.
// Expectations for non-firing neurons follow STDP_SEARCH_EN when it is defined for the build.
module tb_tnn_column;
  localparam int NI = 8;
  localparam int NN = 4;

  typedef struct {
    int         lat;
    logic [3:0] ost;
    logic [1:0] win;
    logic       valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   mw [NN][NI];
  exp_t sb [$];

  tnn_column_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .TBITS(3)) bus ();

  tnn_column dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkWeights(input string tag);
    logic [23:0] obs;
    logic [23:0] exp;
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++) begin
        obs[i*3 +: 3] = dut.weights[n][i];
        exp[i*3 +: 3] = 3'(mw[n][i]);
      end
      checkValue($sformatf("%s.w%0d", tag, n), {8'h0, obs}, {8'h0, exp});
    end
  endtask

  function automatic void modelReset();
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < NI; i++) mw[n][i] = 2;
  endfunction

  // Fire times are found per neuron first, then the earliest (lowest index on ties) wins.
  function automatic void modelVolley(input logic [NI-1:0][3:0] st, input logic trn);
    int   ft [NN];
    int   pot;
    int   win;
    logic act;
    exp_t e;
    for (int n = 0; n < NN; n++) ft[n] = -1;
    for (int tt = 0; tt < 8; tt++) begin
      for (int n = 0; n < NN; n++) begin
        if (ft[n] < 0) begin
          pot = 0;
          for (int i = 0; i < NI; i++)
            if (!st[i][3] && (int'(st[i][2:0]) <= tt)) pot += mw[n][i];
          if (pot >= 6) ft[n] = tt;
        end
      end
    end
    win = -1;
    for (int n = 0; n < NN; n++)
      if (ft[n] >= 0 && (win < 0 || ft[n] < ft[win])) win = n;
    e.lat   = trn ? 17 : 9;
    e.valid = (win >= 0);
    e.win   = 2'd0;
    e.ost   = 4'hF;
    if (win >= 0) begin
      e.win = 2'(win);
      e.ost = 4'(ft[win]);
    end
    if (trn) begin
      for (int n = 0; n < NN; n++) begin
        for (int i = 0; i < NI; i++) begin
          act = !st[i][3];
          if (n == win) begin
            mw[n][i] = act ? ((mw[n][i] + 1 > 7) ? 7 : mw[n][i] + 1)
                           : ((mw[n][i] - 1 < 0) ? 0 : mw[n][i] - 1);
          end else if (ft[n] >= 0) begin
            if (act) mw[n][i] = (mw[n][i] - 1 < 0) ? 0 : mw[n][i] - 1;
          end else begin
`ifdef STDP_SEARCH_EN
            if (act) mw[n][i] = (mw[n][i] + 1 > 7) ? 7 : mw[n][i] + 1;
`endif
          end
        end
      end
    end
    sb.push_back(e);
  endfunction

  task automatic applyStimulus(input logic [NI-1:0][3:0] st, input logic trn);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.training    = trn;
    bus.spike_times = st;
    start_cyc       = cyc;
    modelVolley(st, trn);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checkValue("busy_after_start", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    logic [3:0] held;
    e = sb.pop_front();
    while (!bus.done && (cyc - start_cyc) < 100) @(negedge clk);
    checkValue({tag, ".latency"}, cyc - start_cyc, e.lat);
    checkValue({tag, ".out_time"}, {28'b0, bus.out_spike_time}, {28'b0, e.ost});
    checkValue({tag, ".winner"}, {30'b0, bus.winner}, {30'b0, e.win});
    checkValue({tag, ".valid"}, {31'b0, bus.winner_valid}, {31'b0, e.valid});
    held = bus.out_spike_time;
    @(negedge clk);
    checkValue({tag, ".done_pulse"}, {31'b0, bus.done}, 32'd0);
    checkValue({tag, ".busy_clear"}, {31'b0, bus.busy}, 32'd0);
    checkValue({tag, ".out_hold"}, {28'b0, bus.out_spike_time}, {28'b0, e.ost});
    if (held !== e.ost) $display("[TB] note: %s output changed before hold check", tag);
    checkWeights(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  logic [NI-1:0][3:0] v_zero;
  logic [NI-1:0][3:0] v_three;
  logic [NI-1:0][3:0] v_none;
  int   nd;
  int   search_w;

  initial begin
    for (int i = 0; i < NI; i++) begin
      v_zero[i]  = 4'd0;
      v_none[i]  = 4'b1000;
      v_three[i] = (i < 3) ? 4'd2 : 4'b1000;
    end
`ifdef STDP_SEARCH_EN
    search_w = 1;
`else
    search_w = 0;
`endif
    rst             = 1'b1;
    bus.start       = 1'b1;
    bus.training    = 1'b0;
    bus.spike_times = v_zero;
    modelReset();
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkValue("rst.busy", {31'b0, bus.busy}, 32'd0);
    checkValue("rst.done", {31'b0, bus.done}, 32'd0);
    checkValue("rst.winner", {30'b0, bus.winner}, 32'd0);
    checkValue("rst.valid", {31'b0, bus.winner_valid}, 32'd0);
    checkValue("rst.out_time", {28'b0, bus.out_spike_time}, 32'hF);
    checkWeights("rst");

    $display("[TB] all inputs at t=0, inference only");
    applyStimulus(v_zero, 1'b0);
    checkOutput("inf_all0");
    checkValue("inf_all0.winner_const", {30'b0, bus.winner}, 32'd0);
    checkValue("inf_all0.out_const", {28'b0, bus.out_spike_time}, 32'd0);

    $display("[TB] inputs 0-2 at t=2 with learning");
    applyStimulus(v_three, 1'b1);
    checkOutput("learn3");
    checkValue("learn3.out_const", {28'b0, bus.out_spike_time}, 32'd2);
    checkValue("learn3.n0w0", {29'b0, dut.weights[0][0]}, 32'd3);
    checkValue("learn3.n0w3", {29'b0, dut.weights[0][3]}, 32'd1);
    checkValue("learn3.n1w2", {29'b0, dut.weights[1][2]}, 32'd1);
    checkValue("learn3.n3w7", {29'b0, dut.weights[3][7]}, 32'd2);

    $display("[TB] empty volley with learning");
    applyStimulus(v_none, 1'b1);
    checkOutput("empty");
    checkValue("empty.valid_const", {31'b0, bus.winner_valid}, 32'd0);
    checkValue("empty.out_const", {28'b0, bus.out_spike_time}, 32'hF);

    $display("[TB] repeated volley saturation");
    doReset();
    for (int k = 0; k < 8; k++) applyStimulusAndCheck(k);
    checkValue("sat.n0w1", {29'b0, dut.weights[0][1]}, 32'd7);
    checkValue("sat.n0w5", {29'b0, dut.weights[0][5]}, 32'd0);

    $display("[TB] start while busy is ignored");
    applyStimulus(v_three, 1'b1);
    repeat (2) @(negedge clk);
    bus.start       = 1'b1;
    bus.training    = 1'b0;
    bus.spike_times = v_zero;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy_ignore");
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    checkValue("busy_ignore.extra_done", nd, 0);

    $display("[TB] reset in the middle of inference");
    applyStimulus(v_zero, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    modelReset();
    checkValue("midrst.busy", {31'b0, bus.busy}, 32'd0);
    checkValue("midrst.valid", {31'b0, bus.winner_valid}, 32'd0);
    checkValue("midrst.out_time", {28'b0, bus.out_spike_time}, 32'hF);
    checkWeights("midrst");

    $display("[TB] silenced neuron stays quiet");
    doReset();
    applyStimulus(v_zero, 1'b1);
    checkOutput("silence1");
    applyStimulus(v_zero, 1'b1);
    checkOutput("silence2");
    checkValue("silence2.n3w0", {29'b0, dut.weights[3][0]}, 32'd0);
    applyStimulus(v_three, 1'b1);
    checkOutput("silence3");
    checkValue("silence3.n3w0", {29'b0, dut.weights[3][0]}, search_w);
    checkValue("silence3.n3w2", {29'b0, dut.weights[3][2]}, search_w);
    checkValue("silence3.n3w4", {29'b0, dut.weights[3][4]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic applyStimulusAndCheck(input int k);
    applyStimulus(v_three, 1'b1);
    checkOutput($sformatf("sat%0d", k));
  endtask
endmodule
